robot_range_sched: RTL and testbench

- Sequences up to N_SENS ultrasonic range sensors round-robin and feeds the robot controller's 16-bit distance input.
- For each sensor in turn: fire a trigger pulse, time the echo pulse in clock cycles, scale the count, and publish it as a distance sample with a valid strobe and sensor index.
- Also keeps a running minimum over the latest sample of every enabled sensor, for the obstacle-avoidance logic.

---
 rtl/robot_range_sched_if.sv | 39 +++
 rtl/robot_range_sched.sv | 188 ++++++++++++++++++
 tb/tb_robot_range_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/robot_range_sched_if.sv
// Signal bundle between the range scheduler, its sensors and the robot controller.
// The slave modport is the scheduler; the master modport is the controller/sensor side.
interface robot_range_sched_if #(
   parameter int unsigned N_SENS = 4
);
   logic [N_SENS-1:0] en;
   logic [N_SENS-1:0] echo;
   logic [N_SENS-1:0] trig;
   logic [15:0]       dist_v;
   logic              dist_vld;
   logic [2:0]        dist_id;
   logic [15:0]       dist_min;
   logic              timeout_err;
   logic              busy;

   modport master (
      output en,
      output echo,
      input  trig,
      input  dist_v,
      input  dist_vld,
      input  dist_id,
      input  dist_min,
      input  timeout_err,
      input  busy
   );

   modport slave (
      input  en,
      input  echo,
      output trig,
      output dist_v,
      output dist_vld,
      output dist_id,
      output dist_min,
      output timeout_err,
      output busy
   );
endinterface

// File: rtl/robot_range_sched.sv
// Round-robin ultrasonic range sequencer: trigger, time the echo, publish a scaled distance,
// and track the minimum of the latest samples over enabled sensors.
module robot_range_sched #(
   parameter int unsigned N_SENS   = 4,
   parameter int unsigned TRIG_CYC = 10,
   parameter int unsigned TIMEOUT  = 60000,
   parameter int unsigned GAP_CYC  = 100,
   parameter int unsigned SHIFT    = 4
) (
   input logic             clk,
   input logic             rstn,
   robot_range_sched_if.slave bus
);

   localparam int unsigned IW = (N_SENS > 1) ? $clog2(N_SENS) : 1;

   typedef enum logic [2:0] {StIdle, StTrig, StWait, StMeas, StDone, StGap} state_e;

   state_e            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d, rr_idx;
   logic [IW:0]       rr_c;
   logic [15:0]       cnt_q, cnt_d;
   logic              to_q, to_d;
   logic [N_SENS-1:0] echo_s1_q, echo_s2_q, echo_s3_q;
   logic              echo_rise, echo_fall;
   logic [15:0]       stored_q [N_SENS];
   logic [15:0]       shifted, sample;
   logic [15:0]       dist_v_q, dist_min_q, dist_min_d;
   logic [2:0]        dist_id_q;
   logic              dist_vld_q, timeout_err_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         echo_s1_q <= '0;
         echo_s2_q <= '0;
         echo_s3_q <= '0;
      end else begin
         echo_s1_q <= bus.echo;
         echo_s2_q <= echo_s1_q;
         echo_s3_q <= echo_s2_q;
      end
   end

   // Only the selected sensor's edges matter; others are ignored.
   assign echo_rise = echo_s2_q[idx_q] & ~echo_s3_q[idx_q];
   assign echo_fall = ~echo_s2_q[idx_q] & echo_s3_q[idx_q];

   // Next enabled index after idx_q; descending k so the nearest candidate wins.
   always_comb begin
      rr_idx = idx_q;
      rr_c   = '0;
      for (int k = N_SENS; k >= 1; k--) begin
         rr_c = {1'b0, idx_q} + (IW+1)'(k);
         if (rr_c >= (IW+1)'(N_SENS)) begin
            rr_c = rr_c - (IW+1)'(N_SENS);
         end
         if (bus.en[IW'(rr_c)]) begin
            rr_idx = IW'(rr_c);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      unique case (state_q)
         StIdle: begin
            if (|bus.en) begin
               idx_d   = rr_idx;
               cnt_d   = '0;
               to_d    = 1'b0;
               state_d = StTrig;
            end
         end
         StTrig: begin
            if (cnt_q == 16'(TRIG_CYC - 1)) begin
               cnt_d   = '0;
               state_d = StWait;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StWait: begin
            if (echo_rise) begin
               cnt_d   = '0;
               state_d = StMeas;
            end else if (cnt_q == 16'(TIMEOUT - 1)) begin
               cnt_d   = 16'(TIMEOUT);
               to_d    = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StMeas: begin
            // The fall cycle still counts, so the count equals the synchronized high width.
            if (cnt_q == 16'(TIMEOUT - 1)) begin
               cnt_d   = 16'(TIMEOUT);
               to_d    = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 16'd1;
               if (echo_fall) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            cnt_d   = '0;
            state_d = StGap;
         end
         StGap: begin
            if (cnt_q == 16'(GAP_CYC - 1)) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         idx_q   <= IW'(N_SENS - 1);
         cnt_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
      end
   end

   assign shifted = cnt_q >> SHIFT;
   assign sample  = to_q ? 16'hFFFF : ((shifted > 16'hFFFE) ? 16'hFFFE : shifted);

   always_comb begin
      dist_min_d = 16'hFFFF;
      for (int i = 0; i < N_SENS; i++) begin
         if (bus.en[i] && (stored_q[i] < dist_min_d)) begin
            dist_min_d = stored_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N_SENS; i++) begin
            stored_q[i] <= 16'hFFFF;
         end
         dist_v_q      <= 16'hFFFF;
         dist_id_q     <= '0;
         dist_vld_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         dist_min_q    <= 16'hFFFF;
      end else begin
         dist_vld_q    <= (state_q == StDone);
         timeout_err_q <= (state_q == StDone) && to_q;
         dist_min_q    <= dist_min_d;
         if (state_q == StDone) begin
            stored_q[idx_q] <= sample;
            dist_v_q        <= sample;
            dist_id_q       <= 3'(idx_q);
         end
      end
   end

   // Combinational from state so an async reset drops the trigger immediately.
   always_comb begin
      bus.trig = '0;
      if (state_q == StTrig) begin
         bus.trig[idx_q] = 1'b1;
      end
   end

   assign bus.busy        = (state_q != StIdle);
   assign bus.dist_v      = dist_v_q;
   assign bus.dist_vld    = dist_vld_q;
   assign bus.dist_id     = dist_id_q;
   assign bus.dist_min    = dist_min_q;
   assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_robot_range_sched.sv
// Directed bench for robot_range_sched with a shortened echo timeout to keep runs brief.
module tb_robot_range_sched;

   localparam int unsigned TO = 1000;

   logic clk;
   logic rstn;
   int   total;
   int   bad;
   logic [3:0] trig_acc;

   robot_range_sched_if #(.N_SENS(4)) bus ();

   robot_range_sched #(
      .N_SENS  (4),
      .TRIG_CYC(10),
      .TIMEOUT (TO),
      .GAP_CYC (100),
      .SHIFT   (4)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Waits for the trigger of sensor s, checks it is one-hot on s and exactly 10 cycles wide.
   task automatic wait_trig(input logic [1:0] s);
      int n;
      int width;
      logic [3:0] oh;
      oh = 4'b0001 << s;
      n  = 0;
      while (bus.trig == 4'b0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("trig_sel", 32'(bus.trig), 32'(oh));
      width = 0;
      while (bus.trig != 4'b0 && width < 50) begin
         trig_acc = trig_acc | bus.trig;
         @(negedge clk);
         width++;
      end
      check("trig_width", 32'(width), 32'd10);
   endtask

   // One full service of sensor s with an echo h cycles wide (h=0: no echo).
   task automatic serve(input logic [1:0] s, input int h, input logic [15:0] exp_d,
                        input logic exp_to);
      int n;
      wait_trig(s);
      n = 0;
      while (!bus.dist_vld && n < 3000) begin
         if (h > 0) bus.echo[s] = (n >= 3 && n < 3 + h);
         @(negedge clk);
         n++;
      end
      bus.echo[s] = 1'b0;
      check("vld_seen", 32'(bus.dist_vld), 32'd1);
      check("dist_v", 32'(bus.dist_v), 32'(exp_d));
      check("dist_id", 32'(bus.dist_id), 32'(s));
      check("timeout_err", 32'(bus.timeout_err), 32'(exp_to));
      @(negedge clk);
      check("vld_pulse", 32'(bus.dist_vld), 32'd0);
      check("to_pulse", 32'(bus.timeout_err), 32'd0);
   endtask

   initial begin
      int n;
      total    = 0;
      bad      = 0;
      trig_acc = '0;
      bus.en   = '0;
      bus.echo = '0;
      rstn     = 1'b1;
      #2 rstn  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_trig", 32'(bus.trig), 32'd0);
      check("rst_dist_v", 32'(bus.dist_v), 32'hFFFF);
      check("rst_vld", 32'(bus.dist_vld), 32'd0);
      check("rst_id", 32'(bus.dist_id), 32'd0);
      check("rst_min", 32'(bus.dist_min), 32'hFFFF);
      check("rst_to", 32'(bus.timeout_err), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);

      // Single sensor, 160-cycle echo -> 10.
      bus.en = 4'b0001;
      rstn   = 1'b1;
      serve(2'd0, 160, 16'd10, 1'b0);
      check("min_t1", 32'(bus.dist_min), 32'd10);

      // Sensors 1 and 3 alternate; echo noise on disabled sensor 0 is ignored.
      bus.en      = 4'b1010;
      bus.echo[0] = 1'b1;
      trig_acc    = '0;
      serve(2'd1, 320, 16'd20, 1'b0);
      serve(2'd3, 800, 16'd50, 1'b0);
      serve(2'd1, 320, 16'd20, 1'b0);
      serve(2'd3, 800, 16'd50, 1'b0);
      check("min_t2", 32'(bus.dist_min), 32'd20);
      check("trig_bits_t2", 32'(trig_acc), 32'b1010);
      bus.echo[0] = 1'b0;

      // No echo, then echo stuck high past the timeout.
      bus.en = 4'b0100;
      serve(2'd2, 0, 16'hFFFF, 1'b1);
      serve(2'd2, TO + 500, 16'hFFFF, 1'b1);
      serve(2'd2, 480, 16'd30, 1'b0);
      check("min_t4", 32'(bus.dist_min), 32'd30);

      // Async reset mid-measurement on sensor 1.
      bus.en = 4'b0110;
      wait_trig(2'd1);
      bus.echo[1] = 1'b1;
      repeat (20) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check("mid_rst_trig", 32'(bus.trig), 32'd0);
      check("mid_rst_dist_v", 32'(bus.dist_v), 32'hFFFF);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      check("mid_rst_min", 32'(bus.dist_min), 32'hFFFF);
      bus.echo[1] = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      serve(2'd1, 160, 16'd10, 1'b0);

      // Minimum tracking as sensors drop out, then parking in idle.
      bus.en = 4'b0011;
      serve(2'd0, 640, 16'd40, 1'b0);
      serve(2'd1, 240, 16'd15, 1'b0);
      check("min_both", 32'(bus.dist_min), 32'd15);
      bus.en = 4'b0001;
      @(negedge clk);
      check("min_drop1", 32'(bus.dist_min), 32'd40);
      bus.en = 4'b0000;
      n = 0;
      while (bus.busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("idle_busy", 32'(bus.busy), 32'd0);
      trig_acc = '0;
      repeat (50) begin
         trig_acc = trig_acc | bus.trig;
         @(negedge clk);
      end
      check("idle_trig", 32'(trig_acc), 32'd0);
      check("idle_busy_hold", 32'(bus.busy), 32'd0);
      check("idle_min", 32'(bus.dist_min), 32'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
